// File: rtl/imm_gen_stage_pkg.sv
// Shared definitions for the immediate-generation stage: opcodes, format codes, buffer states.
package imm_gen_stage_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_Z    = 3'd6
  } fmt_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/imm_gen_stage_imm_decode.sv
// Combinational RISC-V immediate decoder, instr -> {imm, fmt}, sign-extended to XLEN.
// IMMGEN_CSR_EN: when defined, CSR-immediate instructions decode as FMT_Z.
module imm_decode
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_instr,
  output logic [XLEN-1:0] o_imm,
  output fmt_e            o_fmt
);

  logic signed [11:0] w_imm_i;
  logic signed [11:0] w_imm_s;
  logic signed [12:0] w_imm_b;
  logic signed [31:0] w_imm_u;
  logic signed [20:0] w_imm_j;

  assign w_imm_i = i_instr[31:20];
  assign w_imm_s = {i_instr[31:25], i_instr[11:7]};
  assign w_imm_b = {i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign w_imm_u = {i_instr[31:12], 12'b0};
  assign w_imm_j = {i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};

  // Size casts of signed operands sign-extend to XLEN.
  always_comb begin
    o_imm = '0;
    o_fmt = FMT_NONE;
    case (i_instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        o_imm = XLEN'(w_imm_i);
        o_fmt = FMT_I;
      end
      OPC_STORE: begin
        o_imm = XLEN'(w_imm_s);
        o_fmt = FMT_S;
      end
      OPC_BRANCH: begin
        o_imm = XLEN'(w_imm_b);
        o_fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        o_imm = XLEN'(w_imm_u);
        o_fmt = FMT_U;
      end
      OPC_JAL: begin
        o_imm = XLEN'(w_imm_j);
        o_fmt = FMT_J;
      end
`ifdef IMMGEN_CSR_EN
      OPC_SYSTEM: begin
        if (i_instr[14]) begin
          o_imm = XLEN'(i_instr[19:15]);
          o_fmt = FMT_Z;
        end
      end
`endif
      default: begin
        o_imm = '0;
        o_fmt = FMT_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a 2-entry skid buffer (main M, skid S).
// IMMGEN_CSR_EN is honoured by the imm_decode sub-module.
module imm_gen_stage
  import imm_gen_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ILEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output fmt_e            out_fmt,
  output logic [XLEN-1:0] out_target
);

  buf_state_e      r_state;
  logic [ILEN-1:0] r_m_instr, r_s_instr;
  logic [XLEN-1:0] r_m_pc,    r_s_pc;
  logic [XLEN-1:0] r_m_imm,   r_s_imm;
  fmt_e            r_m_fmt,   r_s_fmt;
  logic [XLEN-1:0] r_m_tgt,   r_s_tgt;

  logic [XLEN-1:0] w_imm;
  fmt_e            w_fmt;
  logic [XLEN-1:0] w_tgt;
  logic            w_accept;
  logic            w_drain;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .i_instr (in_instr[31:0]),
    .o_imm   (w_imm),
    .o_fmt   (w_fmt)
  );

  assign w_tgt    = in_pc + w_imm;
  assign in_ready = (r_state != ST_FULL);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept = in_valid && in_ready;
  assign w_drain  = out_valid && out_ready;

  assign out_instr  = r_m_instr;
  assign out_pc     = r_m_pc;
  assign out_imm    = r_m_imm;
  assign out_fmt    = r_m_fmt;
  assign out_target = r_m_tgt;

  // Target is computed at acceptance so the output side is purely registered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state   <= ST_EMPTY;
      r_m_instr <= '0;
      r_m_pc    <= '0;
      r_m_imm   <= '0;
      r_m_fmt   <= FMT_NONE;
      r_m_tgt   <= '0;
      r_s_instr <= '0;
      r_s_pc    <= '0;
      r_s_imm   <= '0;
      r_s_fmt   <= FMT_NONE;
      r_s_tgt   <= '0;
    end else if (flush) begin
      r_state <= ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            r_m_instr <= in_instr;
            r_m_pc    <= in_pc;
            r_m_imm   <= w_imm;
            r_m_fmt   <= w_fmt;
            r_m_tgt   <= w_tgt;
            r_state   <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            r_m_instr <= in_instr;
            r_m_pc    <= in_pc;
            r_m_imm   <= w_imm;
            r_m_fmt   <= w_fmt;
            r_m_tgt   <= w_tgt;
          end else if (w_accept) begin
            r_s_instr <= in_instr;
            r_s_pc    <= in_pc;
            r_s_imm   <= w_imm;
            r_s_fmt   <= w_fmt;
            r_s_tgt   <= w_tgt;
            r_state   <= ST_FULL;
          end else if (w_drain) begin
            r_state <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            r_m_instr <= r_s_instr;
            r_m_pc    <= r_s_pc;
            r_m_imm   <= r_s_imm;
            r_m_fmt   <= r_s_fmt;
            r_m_tgt   <= r_s_tgt;
            r_state   <= ST_ONE;
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (XLEN=32 instance plus an XLEN=64 instance).
module tb_imm_gen_stage;
  import imm_gen_stage_pkg::*;

  logic        clk;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_imm;
  fmt_e        out_fmt;
  logic [31:0] out_target;

  logic        v64;
  logic        rdy64;
  logic [31:0] instr64;
  logic [63:0] pc64;
  logic        ov64;
  logic [31:0] oinstr64;
  logic [63:0] opc64;
  logic [63:0] oimm64;
  fmt_e        ofmt64;
  logic [63:0] otgt64;

  int n_cmp = 0;
  int n_mis = 0;

  imm_gen_stage #(.XLEN(32), .ILEN(32)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_target(out_target)
  );

  imm_gen_stage #(.XLEN(64), .ILEN(32)) dut64 (
    .clk(clk), .rstn(rstn), .flush(1'b0),
    .in_valid(v64), .in_ready(rdy64), .in_instr(instr64), .in_pc(pc64),
    .out_valid(ov64), .out_ready(1'b1), .out_instr(oinstr64), .out_pc(opc64),
    .out_imm(oimm64), .out_fmt(ofmt64), .out_target(otgt64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; flush = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h100;
    out_ready = 1'b1; v64 = 1'b0; instr64 = '0; pc64 = '0;
    step(); step();
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready got %0b want 1", in_ready); end
    n_cmp++; if ({out_instr, out_pc, out_imm, out_target} !== 128'h0) begin n_mis++;
      $display("FAIL reset_data got %h %h %h %h want all 0", out_instr, out_pc, out_imm, out_target); end
    n_cmp++; if (out_fmt !== FMT_NONE) begin n_mis++; $display("FAIL reset_fmt got %0d want 0", out_fmt); end
    rstn = 1'b1; flush = 1'b0; in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mis++;
      $display("FAIL post_reset_idle got valid=%0b ready=%0b want 0/1", out_valid, in_ready); end
  endtask

  // Streams one instruction per cycle with out_ready=1; each result must appear one cycle later.
  task automatic test_decode32();
    logic [31:0] t_instr [11];
    logic [31:0] t_pc    [11];
    logic [31:0] t_imm   [11];
    fmt_e        t_fmt   [11];
    logic [31:0] t_tgt   [11];
    t_instr[0]  = 32'hFFF00093; t_pc[0]  = 32'h100; t_imm[0]  = 32'hFFFFFFFF; t_fmt[0]  = FMT_I; t_tgt[0]  = 32'h0FF;
    t_instr[1]  = 32'hFE000EE3; t_pc[1]  = 32'h200; t_imm[1]  = 32'hFFFFFFFC; t_fmt[1]  = FMT_B; t_tgt[1]  = 32'h1FC;
    t_instr[2]  = 32'h00112423; t_pc[2]  = 32'h300; t_imm[2]  = 32'h8;        t_fmt[2]  = FMT_S; t_tgt[2]  = 32'h308;
    t_instr[3]  = 32'hFE112E23; t_pc[3]  = 32'h304; t_imm[3]  = 32'hFFFFFFFC; t_fmt[3]  = FMT_S; t_tgt[3]  = 32'h300;
    t_instr[4]  = 32'h0080006F; t_pc[4]  = 32'h308; t_imm[4]  = 32'h8;        t_fmt[4]  = FMT_J; t_tgt[4]  = 32'h310;
    t_instr[5]  = 32'h00001297; t_pc[5]  = 32'h400; t_imm[5]  = 32'h1000;     t_fmt[5]  = FMT_U; t_tgt[5]  = 32'h1400;
    t_instr[6]  = 32'hFFC08067; t_pc[6]  = 32'h404; t_imm[6]  = 32'hFFFFFFFC; t_fmt[6]  = FMT_I; t_tgt[6]  = 32'h400;
    t_instr[7]  = 32'h00412083; t_pc[7]  = 32'h408; t_imm[7]  = 32'h4;        t_fmt[7]  = FMT_I; t_tgt[7]  = 32'h40C;
    t_instr[8]  = 32'h00000033; t_pc[8]  = 32'h40C; t_imm[8]  = 32'h0;        t_fmt[8]  = FMT_NONE; t_tgt[8] = 32'h40C;
`ifdef IMMGEN_CSR_EN
    t_instr[9]  = 32'h300FD073; t_pc[9]  = 32'h500; t_imm[9]  = 32'h1F;       t_fmt[9]  = FMT_Z; t_tgt[9]  = 32'h51F;
`else
    t_instr[9]  = 32'h300FD073; t_pc[9]  = 32'h500; t_imm[9]  = 32'h0;        t_fmt[9]  = FMT_NONE; t_tgt[9] = 32'h500;
`endif
    t_instr[10] = 32'h800000B7; t_pc[10] = 32'h80000000; t_imm[10] = 32'h80000000; t_fmt[10] = FMT_U; t_tgt[10] = 32'h0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = t_instr[i]; in_pc = t_pc[i];
      step();
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin n_mis++;
        $display("FAIL dec%0d_handshake got valid=%0b ready=%0b want 1/1", i, out_valid, in_ready); end
      n_cmp++; if (out_instr !== t_instr[i] || out_pc !== t_pc[i]) begin n_mis++;
        $display("FAIL dec%0d_passthru got %h/%h want %h/%h", i, out_instr, out_pc, t_instr[i], t_pc[i]); end
      n_cmp++; if (out_imm !== t_imm[i] || out_fmt !== t_fmt[i]) begin n_mis++;
        $display("FAIL dec%0d_imm got %h fmt %0d want %h fmt %0d", i, out_imm, out_fmt, t_imm[i], t_fmt[i]); end
      n_cmp++; if (out_target !== t_tgt[i]) begin n_mis++;
        $display("FAIL dec%0d_target got %h want %h", i, out_target, t_tgt[i]); end
    end
    in_valid = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++; $display("FAIL dec_drain_empty got %0b want 0", out_valid); end
  endtask

  task automatic test_lui64();
    v64 = 1'b1; instr64 = 32'h123452B7; pc64 = 64'h1000;
    step();
    n_cmp++; if (ov64 !== 1'b1 || oimm64 !== 64'h0000000012345000 || ofmt64 !== FMT_U) begin n_mis++;
      $display("FAIL lui64_pos got v=%0b imm %h fmt %0d want 1 0000000012345000 4", ov64, oimm64, ofmt64); end
    n_cmp++; if (otgt64 !== 64'h0000000012346000) begin n_mis++;
      $display("FAIL lui64_pos_target got %h want 0000000012346000", otgt64); end
    instr64 = 32'h800002B7;
    step();
    n_cmp++; if (oimm64 !== 64'hFFFFFFFF80000000 || ofmt64 !== FMT_U) begin n_mis++;
      $display("FAIL lui64_neg got imm %h fmt %0d want FFFFFFFF80000000 4", oimm64, ofmt64); end
    n_cmp++; if (otgt64 !== 64'hFFFFFFFF80001000) begin n_mis++;
      $display("FAIL lui64_neg_target got %h want FFFFFFFF80001000", otgt64); end
    instr64 = 32'hFE000EE3;
    step();
    n_cmp++; if (oimm64 !== 64'hFFFFFFFFFFFFFFFC || ofmt64 !== FMT_B) begin n_mis++;
      $display("FAIL br64 got imm %h fmt %0d want FFFFFFFFFFFFFFFC 3", oimm64, ofmt64); end
    v64 = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h10;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'hFFF00093 || in_ready !== 1'b1) begin n_mis++;
      $display("FAIL bp_one got v=%0b instr %h rdy=%0b want 1 FFF00093 1", out_valid, out_instr, in_ready); end
    in_instr = 32'h00112423; in_pc = 32'h14;
    step();
    n_cmp++; if (in_ready !== 1'b0 || out_instr !== 32'hFFF00093 || out_pc !== 32'h10) begin n_mis++;
      $display("FAIL bp_full got rdy=%0b instr %h pc %h want 0 FFF00093 10", in_ready, out_instr, out_pc); end
    in_instr = 32'h0080006F; in_pc = 32'h18;
    step();
    n_cmp++; if (in_ready !== 1'b0 || out_instr !== 32'hFFF00093 || out_imm !== 32'hFFFFFFFF) begin n_mis++;
      $display("FAIL bp_hold got rdy=%0b instr %h imm %h want 0 FFF00093 FFFFFFFF", in_ready, out_instr, out_imm); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h00112423 || out_target !== 32'h1C || in_ready !== 1'b1) begin n_mis++;
      $display("FAIL bp_second got v=%0b instr %h tgt %h rdy=%0b want 1 00112423 1C 1", out_valid, out_instr, out_target, in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++;
      $display("FAIL bp_no_dup got v=%0b instr %h want v=0", out_valid, out_instr); end
  endtask

  task automatic test_flush_and_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFF00093; in_pc = 32'h20; step();
    in_instr = 32'h00112423; in_pc = 32'h24; step();
    flush = 1'b1; in_instr = 32'h0080006F; in_pc = 32'h28;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_mis++;
      $display("FAIL flush_empty got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++;
      $display("FAIL flush_drop got v=%0b instr %h want v=0", out_valid, out_instr); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE000EE3; in_pc = 32'h30; step();
    in_instr = 32'h00001297; in_pc = 32'h34; step();
    rstn = 1'b0;
    step();
    n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_instr !== 32'h0 || out_target !== 32'h0) begin n_mis++;
      $display("FAIL midreset got v=%0b rdy=%0b instr %h tgt %h want 0 1 0 0", out_valid, in_ready, out_instr, out_target); end
    rstn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_mis++;
      $display("FAIL midreset_after got v=%0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_decode32();
    test_lui64();
    test_backpressure();
    test_flush_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
